// File: rtl/pipeline_stage_chain.sv
// pipeline_stage_chain: elastic valid/ready register chain with per-stage flush.
// Stage 0 is the entry and stage NUM_STAGES-1 is the exit. The ready path is
// combinational from out_ready_i back to in_ready_o, so a full chain can accept
// a new entry in the same cycle that the downstream consumer drains one.
`timescale 1ns/1ps

module pipeline_stage_chain #(
  parameter int NUM_STAGES = 5,
  parameter int DATA_W     = 64,
  parameter int CNT_W      = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [DATA_W-1:0]                 in_data_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [DATA_W-1:0]                 out_data_o,
  input  logic [NUM_STAGES-1:0]             flush_i,
  output logic [NUM_STAGES-1:0]             stage_valid_o,
  output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy_o,
  output logic [CNT_W-1:0]                  drop_count_o
);

  localparam int OCC_W = $clog2(NUM_STAGES+1);
  // Largest per-edge increment is every stage flushed plus a killed input.
  localparam int INC_W = $clog2(NUM_STAGES+2);
  localparam int SUM_W = CNT_W + INC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_d;
  logic [DATA_W-1:0]     data_q [NUM_STAGES];
  logic [DATA_W-1:0]     data_d [NUM_STAGES];
  logic [CNT_W-1:0]      drop_q;
  logic [CNT_W-1:0]      drop_d;

  // Effective valid: a flushed stage behaves as empty this cycle.
  logic [NUM_STAGES-1:0] eff_valid;
  // adv[k]=1 means stage k takes its upstream neighbour's content at the edge.
  logic [NUM_STAGES:0]   adv;
  logic                  in_fire;
  logic                  in_kill;
  logic [INC_W-1:0]      drop_inc;
  logic [SUM_W-1:0]      drop_sum;
  logic [OCC_W-1:0]      occ;

  assign eff_valid = valid_q & ~flush_i;

  // Ready chain, evaluated from the exit back to the entry.
  always_comb begin
    adv = '0;
    adv[NUM_STAGES] = out_ready_i;
    for (int k = NUM_STAGES-1; k >= 0; k--) begin
      adv[k] = ~eff_valid[k] | adv[k+1];
    end
  end

  assign in_ready_o  = adv[0] & ~reset_i;
  assign out_valid_o = eff_valid[NUM_STAGES-1] & ~reset_i;
  assign out_data_o  = data_q[NUM_STAGES-1];
  assign in_fire     = in_valid_i & in_ready_o;
  // Accepted-but-flushed input: handshake completes, entry is discarded.
  assign in_kill     = in_fire & flush_i[0];

  // Per-stage next state: take the upstream entry when advancing, else hold.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    if (gi == 0) begin : g_head
      assign src_valid = in_valid_i & ~flush_i[0];
      assign src_data  = in_data_i;
    end else begin : g_body
      assign src_valid = eff_valid[gi-1];
      assign src_data  = data_q[gi-1];
    end
    assign valid_d[gi] = adv[gi] ? src_valid : valid_q[gi];
    // Payload only moves with a live entry, so bubbles leave data untouched.
    assign data_d[gi]  = (adv[gi] && src_valid) ? src_data : data_q[gi];
  end

  // Occupancy and drop-count increment from the registered valid bits.
  always_comb begin
    occ      = '0;
    drop_inc = INC_W'(in_kill);
    for (int k = 0; k < NUM_STAGES; k++) begin
      occ      = occ + OCC_W'(valid_q[k]);
      drop_inc = drop_inc + INC_W'(valid_q[k] & flush_i[k]);
    end
    drop_sum = SUM_W'(drop_q) + SUM_W'(drop_inc);
    drop_d   = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
  end

  // Stage registers and saturating drop counter; reset discards everything silently.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      drop_q  <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      drop_q  <= drop_d;
      for (int k = 0; k < NUM_STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign stage_valid_o = valid_q;
  assign occupancy_o   = occ;
  assign drop_count_o  = drop_q;

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Bench for pipeline_stage_chain: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a slot-shuffle model.
`timescale 1ns/1ps

module tb_pipeline_stage_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  flush;
  logic [4:0]  stage_valid;
  logic [2:0]  occupancy;
  logic [15:0] drop;

  // Small instance used for the counter saturation scenario.
  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_in_data;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_out_data;
  logic [2:0]  s_flush;
  logic [2:0]  s_stage_valid;
  logic [1:0]  s_occ;
  logic [1:0]  s_drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_stage_chain #(.NUM_STAGES(5), .DATA_W(64), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .flush_i(flush), .stage_valid_o(stage_valid),
    .occupancy_o(occupancy), .drop_count_o(drop)
  );

  pipeline_stage_chain #(.NUM_STAGES(3), .DATA_W(8), .CNT_W(2)) dut_small (
    .clk_i(clk), .reset_i(rst),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_data_i(s_in_data),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .out_data_o(s_out_data),
    .flush_i(s_flush), .stage_valid_o(s_stage_valid),
    .occupancy_o(s_occ), .drop_count_o(s_drop)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Reference model: the chain is five slots. Each edge, flushed slots empty,
  // the exit slot leaves if consumed, every entry slides forward into a free
  // slot ahead of it, and a new entry lands in slot 0 if it is free.
  initial begin : model
    bit          mv [5];
    logic [63:0] md [5];
    bit          sv [5];
    logic [63:0] sd [5];
    logic [4:0]  packed_v;
    int          mdrop;
    int          cnt;
    bit          known;
    bit          exp_ov;
    bit          exp_ir;
    known = 0;
    mdrop = 0;
    for (int k = 0; k < 5; k++) begin
      mv[k] = 0;
      md[k] = '0;
    end
    forever begin
      @(negedge clk);
      if (known) begin
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
          packed_v[k] = mv[k];
          cnt += int'(mv[k]);
        end
        chk("m_stage_valid", 64'(stage_valid), 64'(packed_v));
        chk("m_occupancy", 64'(occupancy), 64'(cnt));
        chk("m_drop_count", 64'(drop), 64'(mdrop));
      end
      for (int k = 0; k < 5; k++) begin
        sv[k] = mv[k] && !flush[k];
        sd[k] = md[k];
      end
      exp_ov = sv[4] && !rst;
      if (sv[4] && out_ready) sv[4] = 0;
      for (int k = 4; k >= 1; k--) begin
        if (!sv[k] && sv[k-1]) begin
          sv[k]   = 1;
          sd[k]   = sd[k-1];
          sv[k-1] = 0;
        end
      end
      exp_ir = !sv[0] && !rst;
      if (known) begin
        chk("m_in_ready", 64'(in_ready), 64'(exp_ir));
        chk("m_out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) chk("m_out_data", out_data, md[4]);
      end
      if (rst) begin
        for (int k = 0; k < 5; k++) mv[k] = 0;
        mdrop = 0;
        known = 1;
      end else if (known) begin
        cnt = 0;
        for (int k = 0; k < 5; k++) cnt += int'(mv[k] && flush[k]);
        if (in_valid && exp_ir && flush[0]) cnt++;
        mdrop = (mdrop + cnt > 65535) ? 65535 : mdrop + cnt;
        if (in_valid && exp_ir && !flush[0]) begin
          sv[0] = 1;
          sd[0] = in_data;
        end
        for (int k = 0; k < 5; k++) begin
          mv[k] = sv[k];
          md[k] = sd[k];
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1; in_valid = 0; in_data = '0; out_ready = 0; flush = '0;
    s_in_valid = 0; s_in_data = '0; s_out_ready = 0; s_flush = '0;
    step(); step();
    settle();
    chk("reset_stage_valid", 64'(stage_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_drop", 64'(drop), 64'd0);
    step();
    rst = 0;

    // Scenario 1: stream 0x1..0x5 with out_ready high.
    out_ready = 1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1; in_data = 64'(i);
      settle();
      chk("t1_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 0;
    settle();
    chk("t1_occupancy_peak", 64'(occupancy), 64'd5);
    for (int j = 1; j <= 5; j++) begin
      chk("t1_out_valid", 64'(out_valid), 64'd1);
      chk("t1_out_data", out_data, 64'(j));
      step();
      settle();
    end
    chk("t1_out_valid_end", 64'(out_valid), 64'd0);
    chk("t1_occupancy_end", 64'(occupancy), 64'd0);

    // Scenario 2: back-pressure fills the chain, then release.
    step();
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 7; i++) begin
      in_data = 64'h10 + 64'(i);
      settle();
      chk("t2_in_ready", 64'(in_ready), 64'(i < 5));
      step();
    end
    in_data = 64'h20; out_ready = 1;
    settle();
    chk("t2_occupancy_full", 64'(occupancy), 64'd5);
    chk("t2_ready_same_cycle", 64'(in_ready), 64'd1);
    chk("t2_out_data", out_data, 64'h10);
    step();
    for (int i = 1; i <= 3; i++) begin
      in_data = 64'h20 + 64'(i);
      settle();
      chk("t2_stream_data", out_data, 64'h10 + 64'(i));
      chk("t2_stream_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 0;
    repeat (8) step();

    // Scenario 3: flush the three youngest stages of a full, stalled chain.
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = 64'hA0 + 64'(i);
      step();
    end
    in_valid = 0; flush = 5'b00111;
    settle();
    chk("t3_exit_visible", 64'(out_valid), 64'd1);
    step();
    flush = '0;
    settle();
    chk("t3_stage_valid", 64'(stage_valid), 64'b11000);
    chk("t3_occupancy", 64'(occupancy), 64'd2);
    chk("t3_drop", 64'(drop), 64'd3);
    step();
    out_ready = 1;
    settle();
    chk("t3_first", out_data, 64'hA0);
    step();
    settle();
    chk("t3_second", out_data, 64'hA1);
    step();
    settle();
    chk("t3_empty", 64'(out_valid), 64'd0);

    // Scenario 4: flush the exit while downstream is ready.
    step();
    out_ready = 0; in_valid = 1; in_data = 64'hB0;
    step();
    in_data = 64'hB1;
    step();
    in_valid = 0;
    repeat (5) step();
    out_ready = 1; flush = 5'b10000;
    settle();
    chk("t4_out_valid_killed", 64'(out_valid), 64'd0);
    chk("t4_in_ready", 64'(in_ready), 64'd1);
    step();
    flush = '0;
    settle();
    chk("t4_moved_in", out_data, 64'hB1);
    chk("t4_stage_valid", 64'(stage_valid), 64'b10000);
    chk("t4_drop", 64'(drop), 64'd4);
    step();
    settle();
    chk("t4_drained", 64'(occupancy), 64'd0);

    // Scenario 5: reset in the middle of a stream.
    step();
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = 64'hC0 + 64'(i);
      step();
    end
    flush = 5'b00010; in_data = 64'hC3;
    step();
    flush = '0; rst = 1; in_data = 64'hC4;
    settle();
    chk("t5_in_ready_rst", 64'(in_ready), 64'd0);
    chk("t5_out_valid_rst", 64'(out_valid), 64'd0);
    step();
    rst = 0; in_valid = 0;
    settle();
    chk("t5_stage_valid", 64'(stage_valid), 64'd0);
    chk("t5_drop", 64'(drop), 64'd0);
    chk("t5_occupancy", 64'(occupancy), 64'd0);

    // Scenario 6: CNT_W=2 counter saturates at 3.
    for (int r = 0; r < 5; r++) begin
      step();
      s_out_ready = 0; s_in_valid = 1; s_in_data = 8'(r + 1);
      settle();
      chk("t6_in_ready", 64'(s_in_ready), 64'd1);
      step();
      s_in_valid = 0;
      repeat (3) step();
      settle();
      chk("t6_exit_valid", 64'(s_out_valid), 64'd1);
      chk("t6_exit_data", 64'(s_out_data), 64'(r + 1));
      s_flush = 3'b100;
      #1;
      chk("t6_flushed_invisible", 64'(s_out_valid), 64'd0);
      step();
      s_flush = '0;
      settle();
      chk("t6_drop", 64'(s_drop), 64'((r < 2) ? r + 1 : 3));
      chk("t6_empty", 64'(s_occ), 64'd0);
    end

    // Randomized traffic, checked by the model every cycle.
    step();
    for (int c = 0; c < 4000; c++) begin
      int rdy_pct;
      rdy_pct = ((c / 64) % 3 == 0) ? 2 : 7;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < rdy_pct);
      in_data   = {$urandom, $urandom};
      for (int k = 0; k < 5; k++) flush[k] = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 0; in_valid = 0; flush = '0; out_ready = 1;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
